// File: rtl/cla_pkg.sv
// Shared constants and FSM state encoding for the serial carry-lookahead adder.
package cla_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/cla4_slice.sv
// Combinational 4-bit carry-lookahead slice: every carry is formed directly
// from generate/propagate terms and the slice carry-in, with no rippling.
module cla4_slice
  import cla_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                ci,
  output logic [NIBBLE_W-1:0] s,
  output logic                co
);

  logic [NIBBLE_W-1:0] g;
  logic [NIBBLE_W-1:0] p;
  logic [NIBBLE_W-1:0] c;

  assign g = a & b;
  assign p = a ^ b;

  assign c[0] = ci;
  assign c[1] = g[0] | (p[0] & ci);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & ci);
  assign co   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & ci);

  assign s = p ^ c;

endmodule

// File: rtl/serial_cla_adder.sv
// Multi-cycle adder: one shared 4-bit lookahead slice walks the operands a
// nibble per clock, carrying between slices through a register.
module serial_cla_adder
  import cla_pkg::*;
#(
  parameter  int NIBBLES = 4,
  localparam int W       = NIBBLE_W * NIBBLES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         overflow
);

  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_t               state;
  state_t               next_state;
  logic [W-1:0]         op_a;
  logic [W-1:0]         op_b;
  logic                 carry;
  logic [IDX_W-1:0]     idx;
  logic [NIBBLE_W-1:0]  slice_a;
  logic [NIBBLE_W-1:0]  slice_b;
  logic [NIBBLE_W-1:0]  slice_s;
  logic                 slice_co;
  logic                 last_slice;

  assign slice_a    = op_a[idx*NIBBLE_W +: NIBBLE_W];
  assign slice_b    = op_b[idx*NIBBLE_W +: NIBBLE_W];
  assign last_slice = (idx == LAST_IDX);

  cla4_slice u_slice (
    .a  (slice_a),
    .b  (slice_b),
    .ci (carry),
    .s  (slice_s),
    .co (slice_co)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (in_valid) next_state = ADD;
        else          next_state = IDLE;
      end
      ADD: begin
        if (last_slice) next_state = DONE;
        else            next_state = ADD;
      end
      DONE: begin
        if (out_ready) next_state = IDLE;
        else           next_state = DONE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Handshake decodes come only from the state register
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  // Operand capture and per-nibble accumulation; results persist through IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a     <= '0;
      op_b     <= '0;
      carry    <= 1'b0;
      idx      <= '0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_a  <= a;
            op_b  <= b;
            carry <= cin;
            idx   <= '0;
          end
        end
        ADD: begin
          sum[idx*NIBBLE_W +: NIBBLE_W] <= slice_s;
          carry                         <= slice_co;
          if (last_slice) begin
            cout     <= slice_co;
            overflow <= (op_a[W-1] == op_b[W-1]) && (slice_s[NIBBLE_W-1] != op_a[W-1]);
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/serial_cla_adder.md
SERIAL_CLA_ADDER -- requirements
Module: serial_cla_adder

Interface
REQ-001 SHALL have parameter NIBBLES, default 4, giving the number of 4-bit slices per operand; operand width W = 4*NIBBLES.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-004 SHALL have port in_valid, input, 1, operands a, b and cin are valid.
REQ-005 SHALL have port in_ready, output, 1, block can accept operands.
REQ-006 SHALL have port a, input, W, addend A, unsigned or two's complement.
REQ-007 SHALL have port b, input, W, addend B.
REQ-008 SHALL have port cin, input, 1, carry into bit 0.
REQ-009 SHALL have port out_valid, output, 1, the result on sum, cout and overflow is valid.
REQ-010 SHALL have port out_ready, input, 1, the consumer accepts the result.
REQ-011 SHALL have port sum, output, W, registered sum.
REQ-012 SHALL have port cout, output, 1, carry out of bit W-1.
REQ-013 SHALL have port overflow, output, 1, two's-complement signed overflow.

Function
REQ-014 SHALL implement a three-state FSM with states IDLE, ADD and DONE.
REQ-015 in_ready SHALL equal (state==IDLE); out_valid SHALL equal (state==DONE); both outputs SHALL be registered-state decodes with no combinational input-to-output paths.
REQ-016 In IDLE, on an edge where in_valid=1, the block SHALL capture a, b and cin into internal registers, clear the slice index idx to 0, and go to ADD.
REQ-017 In ADD, each edge SHALL add captured nibble idx of A and B with the running carry through one 4-bit carry-lookahead slice, write the 4-bit result into sum[4*idx+3:4*idx], and update the running carry with the slice carry-out.
REQ-018 The running carry SHALL be initialised to cin for idx 0.
REQ-019 When ADD processes idx=NIBBLES-1, the block SHALL latch cout as that slice's carry-out, latch overflow = (A[W-1]==B[W-1]) && (result bit W-1 != A[W-1]), and go to DONE.
REQ-020 Latency SHALL be exactly NIBBLES rising edges from the accepting edge to the first cycle with out_valid=1; this is 4 edges at the default parameter value.
REQ-021 In DONE, sum, cout and overflow SHALL hold stable while out_ready=0, with no upper limit on the hold time.
REQ-022 In DONE, on an edge where out_ready=1, the block SHALL go to IDLE, so in_ready=1 in the next cycle; operation is non-overlapped, so at most one operation is in flight.
REQ-023 Changes on a, b, cin or in_valid after the accepting edge SHALL NOT affect the result in flight.
REQ-024 In ADD and DONE, in_valid SHALL be ignored and no operands captured.
REQ-025 sum, cout and overflow SHALL retain the last result after returning to IDLE, until the next operation overwrites them.
REQ-026 In IDLE, out_ready SHALL be ignored.

Reset
REQ-027 When rst=1 at an edge, the block SHALL go to IDLE and set sum=0, cout=0, overflow=0, idx=0, running carry=0 and operand registers=0, regardless of the other inputs.
REQ-028 If rst is asserted mid-ADD or in DONE, the operation in flight SHALL be discarded with no out_valid pulse; in the cycle after reset, in_ready=1 and out_valid=0.

Structure
REQ-029 Package cla_pkg SHALL hold the FSM state enum (IDLE, ADD, DONE) and the constant NIBBLE_W=4.
REQ-030 The 4-bit slice SHALL be one combinational sub-module, cla4_slice, with inputs a[3:0], b[3:0], ci and outputs s[3:0], co.
REQ-031 cla4_slice SHALL compute generate g=a&b and propagate p=a^b, and form all carries as lookahead equations from g, p and ci.
REQ-032 serial_cla_adder SHALL instantiate exactly one cla4_slice and reuse it across all slice indices.

Verification
REQ-033 a=0x1234, b=0x4321, cin=0 -> sum=0x5555, cout=0, overflow=0; out_valid rises 4 edges after accept.
REQ-034 a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, overflow=0 (carry ripples through all 4 slices).
REQ-035 a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, overflow=1; also a=0xFFFF, b=0xFFFF, cin=1 -> sum=0xFFFF, cout=1, overflow=0.
REQ-036 Backpressure: hold out_ready=0 for 3 cycles in DONE and toggle a/b/in_valid -> outputs stable, in_ready=0; then out_ready=1 -> in_ready=1 next cycle.
REQ-037 Assert rst for one cycle while idx=2 -> next cycle: in_ready=1, out_valid=0, sum=0; then 0x0F0F+0x0101 -> sum=0x1010.
REQ-038 Random regression (at least 10k ops, random in_valid/out_ready gaps) -> {cout,sum} equals a+b+cin, and overflow matches the reference model.
